// File: rtl/bb_pipe_pkg.sv
// rtl/bb_pipe_pkg.sv - mode type, widths and word transform shared by bb_pipe
package bb_pkg;

  localparam int MODE_W  = 2;
  localparam int COUNT_W = 16;
  localparam int MAX_W   = 64;

  typedef enum logic [MODE_W-1:0] {
    PASS = 2'd0,
    INV  = 2'd1,
    INC  = 2'd2,
    ACC  = 2'd3
  } mode_e;

  // Computed at MAX_W bits; truncating the result to a narrower WIDTH keeps
  // inversion, increment wrap and accumulate wrap exact for that width.
  function automatic logic [MAX_W-1:0] bb_transform(
    input mode_e            mode,
    input logic [MAX_W-1:0] din,
    input logic [MAX_W-1:0] acc
  );
    logic [MAX_W-1:0] r;
    case (mode)
      PASS:    r = din;
      INV:     r = ~din;
      INC:     r = din + MAX_W'(1);
      default: r = acc + din;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bb_pipe_if.sv
// rtl/bb_pipe_if.sv - stream, config and counter-read signals of bb_pipe
interface bb_pipe_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  import bb_pkg::*;

  localparam int CHAN_W = $clog2(CHANNELS);

  logic               io_in_valid;
  logic               io_in_ready;
  logic [WIDTH-1:0]   io_in_bits;
  logic [CHAN_W-1:0]  io_in_chan;
  logic               io_out_valid;
  logic               io_out_ready;
  logic [WIDTH-1:0]   io_out_bits;
  logic [CHAN_W-1:0]  io_out_chan;
  logic               io_cfg_we;
  logic [CHAN_W-1:0]  io_cfg_chan;
  logic [MODE_W-1:0]  io_cfg_mode;
  logic [CHAN_W-1:0]  io_cnt_chan;
  logic [COUNT_W-1:0] io_cnt;

  modport master (
    output io_in_valid, io_in_bits, io_in_chan, io_out_ready,
           io_cfg_we, io_cfg_chan, io_cfg_mode, io_cnt_chan,
    input  io_in_ready, io_out_valid, io_out_bits, io_out_chan, io_cnt
  );

  modport slave (
    input  io_in_valid, io_in_bits, io_in_chan, io_out_ready,
           io_cfg_we, io_cfg_chan, io_cfg_mode, io_cnt_chan,
    output io_in_ready, io_out_valid, io_out_bits, io_out_chan, io_cnt
  );

endinterface

// File: rtl/bb_pipe_stage.sv
// rtl/bb_pipe_stage.sv - one pipeline register (valid, bits, chan) of bb_pipe
module bb_stage #(
  parameter int WIDTH  = 32,
  parameter int CHAN_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_bits,
  input  logic [CHAN_W-1:0] in_chan,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_bits,
  output logic [CHAN_W-1:0] out_chan
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_chan  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_bits  <= in_bits;
      out_chan  <= in_chan;
    end
  end

endmodule

// File: rtl/bb_pipe.sv
// rtl/bb_pipe.sv - multi-channel transform pipeline with global stall and per-channel counters
// Define BB_RAND_INVALID_EN (non-synthesis builds) to drive random data while io_out_valid=0.
module bb_pipe
  import bb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter int CHANNELS = 4
) (
  input logic     clk,
  input logic     reset,
  bb_pipe_if.slave bus
);

  localparam int CHAN_W = $clog2(CHANNELS);
  // Per-channel state is sized to every encodable tag so lookups never go out
  // of bounds; slots at or above CHANNELS are never written.
  localparam int NSLOT = 1 << CHAN_W;

  mode_e              mode_q [NSLOT];
  logic [WIDTH-1:0]   acc_q  [NSLOT];
  logic [COUNT_W-1:0] cnt_q  [NSLOT];

  logic [DEPTH:0]             st_valid;
  logic [DEPTH:0][WIDTH-1:0]  st_bits;
  logic [DEPTH:0][CHAN_W-1:0] st_chan;

  logic             advance;
  logic             accept;
  logic             in_ok;
  logic             cfg_ok;
  logic             cnt_ok;
  mode_e            in_mode;
  logic [WIDTH-1:0] in_acc;
  logic [WIDTH-1:0] xf_bits;

  assign in_ok  = {1'b0, bus.io_in_chan}  < (CHAN_W+1)'(CHANNELS);
  assign cfg_ok = {1'b0, bus.io_cfg_chan} < (CHAN_W+1)'(CHANNELS);
  assign cnt_ok = {1'b0, bus.io_cnt_chan} < (CHAN_W+1)'(CHANNELS);

  assign advance         = ~st_valid[DEPTH] | bus.io_out_ready;
  assign bus.io_in_ready = advance;
  assign accept          = bus.io_in_valid & advance;

  assign in_mode = in_ok ? mode_q[bus.io_in_chan] : PASS;
  assign in_acc  = in_ok ? acc_q[bus.io_in_chan]  : '0;
  assign xf_bits = WIDTH'(bb_transform(in_mode, MAX_W'(bus.io_in_bits), MAX_W'(in_acc)));

  assign st_valid[0] = bus.io_in_valid;
  assign st_bits[0]  = xf_bits;
  assign st_chan[0]  = bus.io_in_chan;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    bb_stage #(
      .WIDTH  (WIDTH),
      .CHAN_W (CHAN_W)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (advance),
      .in_valid  (st_valid[i]),
      .in_bits   (st_bits[i]),
      .in_chan   (st_chan[i]),
      .out_valid (st_valid[i+1]),
      .out_bits  (st_bits[i+1]),
      .out_chan  (st_chan[i+1])
    );
  end

  // The config write is applied after the accumulate update so its clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        mode_q[i] <= PASS;
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      if (accept && in_ok) begin
        if (cnt_q[bus.io_in_chan] != '1) begin
          cnt_q[bus.io_in_chan] <= cnt_q[bus.io_in_chan] + COUNT_W'(1);
        end
        if (in_mode == ACC) begin
          acc_q[bus.io_in_chan] <= xf_bits;
        end
      end
      if (bus.io_cfg_we && cfg_ok) begin
        mode_q[bus.io_cfg_chan] <= mode_e'(bus.io_cfg_mode);
        acc_q[bus.io_cfg_chan]  <= '0;
      end
    end
  end

  assign bus.io_cnt       = cnt_ok ? cnt_q[bus.io_cnt_chan] : '0;
  assign bus.io_out_valid = st_valid[DEPTH];
  assign bus.io_out_chan  = st_chan[DEPTH];

`ifdef BB_RAND_INVALID_EN
`ifndef SYNTHESIS
  assign bus.io_out_bits = st_valid[DEPTH] ? st_bits[DEPTH] : WIDTH'({1{$random}});
`else
  assign bus.io_out_bits = st_valid[DEPTH] ? st_bits[DEPTH] : '0;
`endif
`else
  assign bus.io_out_bits = st_valid[DEPTH] ? st_bits[DEPTH] : '0;
`endif

endmodule

// File: tb/tb_bb_pipe.sv
// tb/tb_bb_pipe.sv - scoreboard bench for bb_pipe (4-channel and 3-channel instances)
module tb_bb_pipe;
  import bb_pkg::*;

  localparam int W = 32;
  localparam int D = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bb_pipe_if #(.WIDTH(W), .CHANNELS(4)) bus ();
  bb_pipe_if #(.WIDTH(W), .CHANNELS(3)) bus3 ();

  bb_pipe #(.WIDTH(W), .DEPTH(D), .CHANNELS(4)) dut  (.clk(clk), .reset(reset), .bus(bus));
  bb_pipe #(.WIDTH(W), .DEPTH(D), .CHANNELS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct {
    logic [31:0] bits;
    logic [1:0]  chan;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];
  exp_t e_m;
  exp_t e_m3;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.io_out_valid && bus.io_out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got 0x%0h with no word expected", bus.io_out_bits);
      end else begin
        e_m = q.pop_front();
        check("out_bits", bus.io_out_bits, e_m.bits);
        check("out_chan", bus.io_out_chan, e_m.chan);
        if (e_m.chk_lat) check("latency", cyc - e_m.acc_cyc, D);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus3.io_out_valid && bus3.io_out_ready) begin
      if (q3.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out3: got 0x%0h with no word expected", bus3.io_out_bits);
      end else begin
        e_m3 = q3.pop_front();
        check("out3_bits", bus3.io_out_bits, e_m3.bits);
        check("out3_chan", bus3.io_out_chan, e_m3.chan);
      end
    end
  end

  // All drivers start and end 1 time unit after a rising edge.
  task automatic send(input logic [1:0] ch, input logic [31:0] d, input logic [31:0] e, input bit lat);
    exp_t x;
    int   k = 0;
    bus.io_in_valid = 1'b1;
    bus.io_in_chan  = ch;
    bus.io_in_bits  = d;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.io_in_ready && k < 50);
    if (!bus.io_in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end else begin
      x.bits = e; x.chan = ch; x.acc_cyc = cyc; x.chk_lat = lat;
      q.push_back(x);
    end
    @(posedge clk); #1;
    bus.io_in_valid = 1'b0;
  endtask

  task automatic send3(input logic [1:0] ch, input logic [31:0] d, input logic [31:0] e);
    exp_t x;
    int   k = 0;
    bus3.io_in_valid = 1'b1;
    bus3.io_in_chan  = ch;
    bus3.io_in_bits  = d;
    do begin
      @(negedge clk);
      k++;
    end while (!bus3.io_in_ready && k < 50);
    if (!bus3.io_in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send3_timeout: in_ready stayed 0, expected 1");
    end else begin
      x.bits = e; x.chan = ch; x.acc_cyc = cyc; x.chk_lat = 1'b0;
      q3.push_back(x);
    end
    @(posedge clk); #1;
    bus3.io_in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input mode_e m);
    bus.io_cfg_we   = 1'b1;
    bus.io_cfg_chan = ch;
    bus.io_cfg_mode = m;
    @(posedge clk); #1;
    bus.io_cfg_we = 1'b0;
  endtask

  task automatic cfg3(input logic [1:0] ch, input mode_e m);
    bus3.io_cfg_we   = 1'b1;
    bus3.io_cfg_chan = ch;
    bus3.io_cfg_mode = m;
    @(posedge clk); #1;
    bus3.io_cfg_we = 1'b0;
  endtask

  task automatic rd_cnt(input string name, input logic [1:0] ch, input logic [15:0] e);
    bus.io_cnt_chan = ch;
    @(negedge clk);
    check(name, bus.io_cnt, e);
    @(posedge clk); #1;
  endtask

  task automatic rd_cnt3(input string name, input logic [1:0] ch, input logic [15:0] e);
    bus3.io_cnt_chan = ch;
    @(negedge clk);
    check(name, bus3.io_cnt, e);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || q3.size() != 0) && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.io_in_valid = 0; bus.io_in_bits = 0; bus.io_in_chan = 0; bus.io_out_ready = 1;
    bus.io_cfg_we = 0; bus.io_cfg_chan = 0; bus.io_cfg_mode = 0; bus.io_cnt_chan = 0;
    bus3.io_in_valid = 0; bus3.io_in_bits = 0; bus3.io_in_chan = 0; bus3.io_out_ready = 1;
    bus3.io_cfg_we = 0; bus3.io_cfg_chan = 0; bus3.io_cfg_mode = 0; bus3.io_cnt_chan = 0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.io_out_valid, 0);
    check("rst_out_bits", bus.io_out_bits, 0);
    check("rst_out_chan", bus.io_out_chan, 0);
    check("rst_in_ready", bus.io_in_ready, 1);
    check("rst_cnt0", bus.io_cnt, 0);
    @(posedge clk); #1;

    send(0, 32'h12345678, 32'h12345678, 1'b1);
    drain();
    rd_cnt("cnt0_pass", 0, 16'd1);

    cfg(1, INV);
    cfg(2, INC);
    send(1, 32'h0000FFFF, 32'hFFFF0000, 1'b0);
    send(2, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    send(2, 32'h00000005, 32'h00000006, 1'b0);
    drain();

    cfg(3, ACC);
    send(3, 32'd5, 32'd5, 1'b0);
    send(3, 32'd7, 32'd12, 1'b0);
    send(3, 32'd1, 32'd13, 1'b0);
    cfg(3, ACC);
    send(3, 32'd2, 32'd2, 1'b0);
    drain();

    bus.io_out_ready = 1'b0;
    send(0, 32'hA1, 32'hA1, 1'b0);
    send(0, 32'hA2, 32'hA2, 1'b0);
    fork
      send(0, 32'hA3, 32'hA3, 1'b0);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("stall_in_ready", bus.io_in_ready, 0);
          check("stall_out_valid", bus.io_out_valid, 1);
          check("stall_out_bits", bus.io_out_bits, 32'hA1);
        end
        @(posedge clk); #1;
        bus.io_out_ready = 1'b1;
      end
    join
    drain();

    bus.io_cfg_we   = 1'b1;
    bus.io_cfg_chan = 2'd1;
    bus.io_cfg_mode = PASS;
    send(1, 32'hA, 32'hFFFFFFF5, 1'b0);
    bus.io_cfg_we = 1'b0;
    send(1, 32'hA, 32'h0000000A, 1'b0);
    drain();
    rd_cnt("cnt1", 1, 16'd3);
    rd_cnt("cnt2", 2, 16'd2);
    rd_cnt("cnt3", 3, 16'd4);

    for (int i = 0; i < 70000; i++) send(0, i, i, 1'b0);
    drain();
    rd_cnt("cnt0_sat", 0, 16'hFFFF);
    rd_cnt("cnt1_untouched", 1, 16'd3);

    send3(3, 32'hDEADBEEF, 32'hDEADBEEF);
    cfg3(3, INV);
    send3(3, 32'h00001234, 32'h00001234);
    cfg3(2, INV);
    send3(2, 32'h00000000, 32'hFFFFFFFF);
    drain();
    rd_cnt3("cnt3_oor", 3, 16'd0);
    rd_cnt3("cnt3_ch0", 0, 16'd0);
    rd_cnt3("cnt3_ch2", 2, 16'd1);

    bus.io_out_ready = 1'b0;
    send(0, 32'h55, 32'h55, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    bus.io_out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.io_cnt_chan = 0;
    @(negedge clk);
    check("midrst_out_valid", bus.io_out_valid, 0);
    check("midrst_cnt0", bus.io_cnt, 0);
    @(posedge clk); #1;
    send(1, 32'hA, 32'hA, 1'b0);
    drain();

    check("q_empty", q.size(), 0);
    check("q3_empty", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bb_pipe.md
# bb_pipe

Parametrised, multi-channel, pipelined replacement for the fixed 32-bit pass-through black box. It carries a channel-tagged data stream through a configurable-latency pipeline with valid/ready flow control. Each word gets a per-channel transform, and the block keeps per-channel transfer counters. It sits between a stream producer and consumer in the top module, in the position the simple black box held.

## Interface
Parameters:
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 2, pipeline latency in cycles (≥1)
- CHANNELS, 4, number of channels (≥2); CHAN_W = $clog2(CHANNELS)

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- io_in_valid  in  1  input word valid
- io_in_ready  out  1  block can accept input
- io_in_bits  in  WIDTH  input data
- io_in_chan  in  CHAN_W  input channel tag
- io_out_valid  out  1  output word valid
- io_out_ready  in  1  consumer accepts output
- io_out_bits  out  WIDTH  transformed data
- io_out_chan  out  CHAN_W  channel tag of output word
- io_cfg_we  in  1  mode write strobe
- io_cfg_chan  in  CHAN_W  channel being configured
- io_cfg_mode  in  2  new mode
- io_cnt_chan  in  CHAN_W  counter read select
- io_cnt  out  16  transfer count of selected channel, combinational read

## Operation
- Accept: io_in_valid & io_in_ready. The transform is applied at acceptance, and the result enters stage 0.
- Modes (per channel, 2 bits):
  - PASS=0: out = in
  - INV=1: out = ~in
  - INC=2: out = in + 1, mod 2^WIDTH, wrapping all-ones to 0
  - ACC=3: out = acc[ch] + in, mod 2^WIDTH; acc[ch] takes the new sum
- Config writes:
  - io_cfg_we writes mode[io_cfg_chan] and clears acc[io_cfg_chan] to 0.
  - When a write and an accept on the same channel occur in the same cycle, the accept uses the old mode and old acc. The write's clear wins over the ACC update.
- Out-of-range channels: a tag ≥ CHANNELS on io_in_chan, io_cfg_chan or io_cnt_chan maps to PASS. It causes no counter or acc update, ignores config writes, and reads 0.
- Counters: cnt[ch] increments on each accept on that channel and saturates at 16'hFFFF. Only reset clears counters.
- Flow control: global stall.
  - advance = ~last_valid | io_out_ready
  - io_in_ready = advance
  - On advance, every stage shifts by one.
  - Bubbles are not collapsed.
- io_out_valid, io_out_bits and io_out_chan come from the last stage.
- Reset values:
  - All stage valids 0.
  - io_out_valid 0, io_out_bits 0, io_out_chan 0.
  - io_in_ready 1 (after the reset cycle).
  - All modes PASS, all acc 0, all counters 0.
- Reset mid-operation: in-flight words are dropped and no output handshake occurs.

## Timing
- Latency: a word accepted in cycle t appears with io_out_valid=1 in cycle t+DEPTH when no stall occurs.
- Throughput: one word per cycle while io_out_ready=1.
- Stall: while io_out_valid=1 and io_out_ready=0, all stages, io_in_ready (0) and the outputs hold.
- Config: a mode written in cycle t applies to accepts in cycle t+1 and later.
- Counter reads reflect accepts up to and including the previous cycle.

## Configuration
- Macro `BB_RAND_INVALID_EN`.
- Defined, and SYNTHESIS not defined: io_out_bits is driven with {1{$random}} in every cycle where io_out_valid=0, so consumers that sample invalid data are exposed.
- Undefined, or under SYNTHESIS: io_out_bits is forced to 0 whenever io_out_valid=0.

## Structure
- Package `bb_pkg`:
  - mode enum (PASS, INV, INC, ACC), MODE_W=2
  - COUNT_W=16
  - transform function (mode, in, acc) → WIDTH result
- Sub-module `bb_stage`: one pipeline register holding valid, bits and chan, with enable=advance and synchronous reset of valid. It is instantiated DEPTH times via generate.
- The top level holds the mode and acc arrays, the counters, the accept logic and the invalid-output masking.

## Test plan
- Reset, then PASS on ch0: send 0x12345678 with io_out_ready=1 → out 0x12345678, chan 0, valid exactly 2 cycles after accept; cnt[0]=1.
- Modes: set ch1=INV, ch2=INC. Send 0x0000FFFF on ch1 → 0xFFFF0000. Send 0xFFFFFFFF on ch2 → 0x00000000.
- ACC on ch3: send 5, 7, 1 back-to-back → outputs 5, 12, 13. Then a cfg write to ch3=ACC, then send 2 → out 2.
- Stall: fill the pipe, then drop io_out_ready for 4 cycles → io_in_ready=0 and outputs hold. On release, the words drain in order with no loss or duplication.
- Simultaneous event: cfg write ch1=PASS and accept 0xA on ch1 (mode INV) in the same cycle → out 0xFFFFFFF5. The next 0xA on ch1 → 0x0000000A.
- Saturation and range: 70000 accepts on ch0 → cnt[0]=0xFFFF. With CHANNELS=3, accept on chan 3 → passed through unchanged and no counter changes.
